// File: rtl/branch_resolve_unit_if.sv
// Bundle of the fetch-slot inputs and the redirect/statistics outputs of
// branch_resolve_unit.
//   master : the side that presents instructions and operands and consumes
//            the redirect requests (fetch unit or a testbench)
//   slave  : branch_resolve_unit itself
// Signals:
//   instr, instr_valid, rs1_data, rs2_data       master -> slave
//   beq, bneq, blt, bge, jump                    slave -> master, 1-cycle pulses
//   imm_address, imm_address_jump                slave -> master, held offsets
//   flush                                        slave -> master, squash window
//   branch_count, taken_count                    slave -> master, saturating stats
interface branch_resolve_unit_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        beq;
  logic        bneq;
  logic        blt;
  logic        bge;
  logic        jump;
  logic [31:0] imm_address;
  logic [31:0] imm_address_jump;
  logic        flush;
  logic [15:0] branch_count;
  logic [15:0] taken_count;

  modport master (
    output instr, instr_valid, rs1_data, rs2_data,
    input  beq, bneq, blt, bge, jump, imm_address, imm_address_jump,
           flush, branch_count, taken_count
  );

  modport slave (
    input  instr, instr_valid, rs1_data, rs2_data,
    output beq, bneq, blt, bge, jump, imm_address, imm_address_jump,
           flush, branch_count, taken_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves BEQ/BNE/BLT/BGE and JAL for the single-issue core and drives the
// fetch unit's redirect requests and offsets. After a taken redirect the
// unit raises flush for FLUSH_CYCLES cycles and ignores its inputs meanwhile.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous active-high reset
//   bus    branch_resolve_unit_if.slave (instruction/operand inputs,
//          request flags, offsets, flush and statistics outputs)
// Parameters:
//   FLUSH_CYCLES  flush window length after a taken redirect (1..15)
//   OFFSET_ADJ    byte count subtracted from every emitted offset (mod 2^32)
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] OFFSET_ADJ   = 32'd0
) (
  input logic            clk,
  input logic            reset,
  branch_resolve_unit_if.slave bus
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t     state;
  logic [3:0] flush_cnt;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_cond;
  logic        cond_taken;
  logic        is_jal;
  logic        eq;
  logic        lt;

  // Decode and compare the current slot; only consumed when in IDLE.
  always_comb begin
    opcode     = bus.instr[6:0];
    funct3     = bus.instr[14:12];
    b_imm      = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                  bus.instr[30:25], bus.instr[11:8], 1'b0};
    j_imm      = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                  bus.instr[20], bus.instr[30:21], 1'b0};
    eq         = (bus.rs1_data == bus.rs2_data);
    lt         = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
    is_cond    = 1'b0;
    cond_taken = 1'b0;
    is_jal     = (opcode == OPC_JAL);
    if (opcode == OPC_BRANCH) begin
      case (funct3)
        3'b000: begin is_cond = 1'b1; cond_taken = eq;  end
        3'b001: begin is_cond = 1'b1; cond_taken = !eq; end
        3'b100: begin is_cond = 1'b1; cond_taken = lt;  end
        3'b101: begin is_cond = 1'b1; cond_taken = !lt; end
        default: begin is_cond = 1'b0; cond_taken = 1'b0; end
      endcase
    end
  end

  // Control FSM with registered outputs. The request flags default low every
  // cycle so they pulse for exactly one cycle. flush_cnt counts the remaining
  // flush cycles after the current one; flush drops on the edge where it is
  // already zero, giving a window of exactly FLUSH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      flush_cnt            <= 4'd0;
      bus.beq              <= 1'b0;
      bus.bneq             <= 1'b0;
      bus.blt              <= 1'b0;
      bus.bge              <= 1'b0;
      bus.jump             <= 1'b0;
      bus.imm_address      <= 32'd0;
      bus.imm_address_jump <= 32'd0;
      bus.flush            <= 1'b0;
      bus.branch_count     <= 16'd0;
      bus.taken_count      <= 16'd0;
    end else begin
      bus.beq  <= 1'b0;
      bus.bneq <= 1'b0;
      bus.blt  <= 1'b0;
      bus.bge  <= 1'b0;
      bus.jump <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            if (is_cond && bus.branch_count != 16'hFFFF) begin
              bus.branch_count <= bus.branch_count + 16'd1;
            end
            if ((is_cond && cond_taken) || is_jal) begin
              if (bus.taken_count != 16'hFFFF) begin
                bus.taken_count <= bus.taken_count + 16'd1;
              end
              bus.flush <= 1'b1;
              flush_cnt <= FLUSH_INIT;
              state     <= FLUSH;
            end
            if (is_cond && cond_taken) begin
              bus.imm_address <= b_imm - OFFSET_ADJ;
              bus.beq  <= (funct3 == 3'b000);
              bus.bneq <= (funct3 == 3'b001);
              bus.blt  <= (funct3 == 3'b100);
              bus.bge  <= (funct3 == 3'b101);
            end
            if (is_jal) begin
              bus.imm_address_jump <= j_imm - OFFSET_ADJ;
              bus.jump             <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            bus.flush <= 1'b0;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          bus.flush <= 1'b0;
          flush_cnt <= 4'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit. Two instances share the same stimulus:
// one with default parameters, one with FLUSH_CYCLES=3 and OFFSET_ADJ=4.
// A cycle-level behavioural model predicts every output of both instances.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int unsigned vector_count = 0;
  int unsigned miscompare_count = 0;
  bit          check_en = 1'b1;

  branch_resolve_unit_if bus0 ();
  branch_resolve_unit_if bus1 ();

  assign bus0.instr       = instr;
  assign bus0.instr_valid = instr_valid;
  assign bus0.rs1_data    = rs1_data;
  assign bus0.rs2_data    = rs2_data;
  assign bus1.instr       = instr;
  assign bus1.instr_valid = instr_valid;
  assign bus1.rs1_data    = rs1_data;
  assign bus1.rs2_data    = rs2_data;

  branch_resolve_unit #(.FLUSH_CYCLES(2), .OFFSET_ADJ(32'd0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  branch_resolve_unit #(.FLUSH_CYCLES(3), .OFFSET_ADJ(32'd4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model state, one slot per instance. m_skip is the number of
  // upcoming clock edges whose inputs are ignored after a redirect.
  int          m_flush_len [2] = '{2, 3};
  int          m_adj       [2] = '{0, 4};
  int          m_skip      [2];
  logic [4:0]  m_flags     [2];
  logic [31:0] m_imm       [2];
  logic [31:0] m_immj      [2];
  logic        m_flush     [2];
  int          m_bc        [2];
  int          m_tc        [2];

  // Offsets rebuilt arithmetically from the instruction fields.
  function automatic int bImmOf(input logic [31:0] i);
    int v;
    v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    return v;
  endfunction

  function automatic int jImmOf(input logic [31:0] i);
    int v;
    v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    return v;
  endfunction

  task automatic modelStep(input int k, input logic rst, input logic [31:0] i,
                           input logic v, input logic [31:0] a, input logic [31:0] b);
    int  sa;
    int  sb;
    bit  taken;
    bit  resolved;
    sa = int'(a);
    sb = int'(b);
    if (rst) begin
      m_skip[k] = 0; m_flags[k] = 5'b0; m_imm[k] = 32'd0; m_immj[k] = 32'd0;
      m_flush[k] = 1'b0; m_bc[k] = 0; m_tc[k] = 0;
      return;
    end
    m_flags[k] = 5'b0;
    if (m_skip[k] > 0) begin
      m_skip[k]--;
    end else if (v) begin
      resolved = 1'b0;
      taken    = 1'b0;
      if (i[6:0] == 7'h63) begin
        case (i[14:12])
          3'd0: begin resolved = 1'b1; taken = (a == b);  end
          3'd1: begin resolved = 1'b1; taken = (a != b);  end
          3'd4: begin resolved = 1'b1; taken = (sa < sb);  end
          3'd5: begin resolved = 1'b1; taken = (sa >= sb); end
          default: ;
        endcase
        if (resolved) m_bc[k] = (m_bc[k] < 65535) ? m_bc[k] + 1 : 65535;
        if (taken) begin
          case (i[14:12])
            3'd0: m_flags[k] = 5'b10000;
            3'd1: m_flags[k] = 5'b01000;
            3'd4: m_flags[k] = 5'b00100;
            default: m_flags[k] = 5'b00010;
          endcase
          m_imm[k]  = 32'(bImmOf(i) - m_adj[k]);
          m_tc[k]   = (m_tc[k] < 65535) ? m_tc[k] + 1 : 65535;
          m_skip[k] = m_flush_len[k];
        end
      end else if (i[6:0] == 7'h6F) begin
        m_flags[k] = 5'b00001;
        m_immj[k]  = 32'(jImmOf(i) - m_adj[k]);
        m_tc[k]    = (m_tc[k] < 65535) ? m_tc[k] + 1 : 65535;
        m_skip[k]  = m_flush_len[k];
      end
    end
    m_flush[k] = (m_skip[k] > 0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("dut0.flags", {27'd0, bus0.beq, bus0.bneq, bus0.blt, bus0.bge, bus0.jump}, {27'd0, m_flags[0]});
    checkOutput("dut0.imm", bus0.imm_address, m_imm[0]);
    checkOutput("dut0.immj", bus0.imm_address_jump, m_immj[0]);
    checkOutput("dut0.flush", {31'd0, bus0.flush}, {31'd0, m_flush[0]});
    checkOutput("dut0.bcount", {16'd0, bus0.branch_count}, 32'(m_bc[0]));
    checkOutput("dut0.tcount", {16'd0, bus0.taken_count}, 32'(m_tc[0]));
    checkOutput("dut1.flags", {27'd0, bus1.beq, bus1.bneq, bus1.blt, bus1.bge, bus1.jump}, {27'd0, m_flags[1]});
    checkOutput("dut1.imm", bus1.imm_address, m_imm[1]);
    checkOutput("dut1.immj", bus1.imm_address_jump, m_immj[1]);
    checkOutput("dut1.flush", {31'd0, bus1.flush}, {31'd0, m_flush[1]});
    checkOutput("dut1.bcount", {16'd0, bus1.branch_count}, 32'(m_bc[1]));
    checkOutput("dut1.tcount", {16'd0, bus1.taken_count}, 32'(m_tc[1]));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check #1 later.
  task automatic applyStimulus(input logic rst, input logic [31:0] i, input logic v,
                               input logic [31:0] a, input logic [31:0] b);
    reset = rst; instr = i; instr_valid = v; rs1_data = a; rs2_data = b;
    @(posedge clk);
    modelStep(0, rst, i, v, a, b);
    modelStep(1, rst, i, v, a, b);
    #1;
    if (check_en) checkAll();
  endtask

  function automatic logic [31:0] randomInstr();
    logic [31:0] r;
    logic [2:0]  f3s [8];
    int          pick;
    f3s  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd6, 3'd2};
    r    = $urandom;
    pick = $urandom_range(0, 9);
    if (pick < 6) begin
      r[6:0]   = 7'h63;
      r[14:12] = f3s[$urandom_range(0, 7)];
    end else if (pick < 8) begin
      r[6:0] = 7'h6F;
    end else begin
      r[6:0] = 7'h13;
    end
    return r;
  endfunction

  function automatic logic [31:0] randomOperand();
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 2)) - 32'd1;
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1; instr = 32'd0; instr_valid = 1'b0; rs1_data = 32'd0; rs2_data = 32'd0;
    m_skip = '{0, 0};
    #2;
    applyStimulus(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

    $display("[TB] directed sequence");
    applyStimulus(1'b0, 32'h00208463, 1'b1, 32'd5, 32'd5);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'h00208463, 1'b1, 32'd5, 32'd6);
    applyStimulus(1'b0, 32'h00209463, 1'b1, 32'd3, 32'd4);
    applyStimulus(1'b0, 32'h00209463, 1'b1, 32'd3, 32'd4);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'h0020C463, 1'b1, 32'hFFFFFFFF, 32'd1);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'h0020D463, 1'b1, 32'hFFFFFFFF, 32'd1);
    applyStimulus(1'b0, 32'hFF1FF06F, 1'b1, 32'd0, 32'd0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

    $display("[TB] reset inside flush window");
    applyStimulus(1'b0, 32'h00208463, 1'b1, 32'd7, 32'd7);
    applyStimulus(1'b1, 32'h00208463, 1'b1, 32'd7, 32'd7);
    applyStimulus(1'b0, 32'h00208463, 1'b1, 32'd7, 32'd8);

    $display("[TB] randomized sequence");
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(($urandom_range(0, 199) == 0), randomInstr(),
                    ($urandom_range(0, 3) != 0), randomOperand(), randomOperand());
    end

    $display("[TB] counter saturation");
    applyStimulus(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    check_en = 1'b0;
    for (int c = 1; c <= 66000; c++) begin
      check_en = ((c % 8192) == 0);
      applyStimulus(1'b0, 32'h00208463, 1'b1, 32'd1, 32'd2);
    end
    check_en = 1'b1;
    applyStimulus(1'b0, 32'h00208463, 1'b1, 32'd1, 32'd2);
    checkOutput("sat.bcount", {16'd0, bus0.branch_count}, 32'h0000FFFF);
    checkOutput("sat.tcount", {16'd0, bus0.taken_count}, 32'd0);
    applyStimulus(1'b0, 32'h00208463, 1'b1, 32'd9, 32'd9);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
